// File: rtl/rv32i_types.sv
// Shared core types: physical register / ROB sizing and the CDB packet layout.
package rv32i_types;

   localparam int PHYS_REG_IDX    = 5;
   localparam int NUM_ROB_ENTRIES = 16;
   localparam int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES);
   localparam int RV_XLEN         = 32;

   typedef struct packed {
      logic                    valid;
      logic [PHYS_REG_IDX:0]   pd;
      logic [ROB_IDX_W-1:0]    rob;
      logic [RV_XLEN-1:0]      value;
      logic                    dest_we;
   } cdb_pkt_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or after ptr_i, wrapping.
module rr_arbiter #(
   parameter int NUM_FU = 4,
   parameter int PW     = $clog2(NUM_FU)
) (
   input  logic [NUM_FU-1:0] req_i,
   input  logic [PW-1:0]     ptr_i,
   output logic [NUM_FU-1:0] gnt_o
);

   logic          found;
   logic [PW:0]   sum;
   logic [PW-1:0] idx;

   // Walk the requesters starting at the pointer, grant the first one seen.
   always_comb begin
      gnt_o = '0;
      found = 1'b0;
      sum   = '0;
      idx   = '0;
      for (int k = 0; k < NUM_FU; k++) begin
         sum = {1'b0, ptr_i} + (PW+1)'(k);
         if (sum >= (PW+1)'(NUM_FU)) sum = sum - (PW+1)'(NUM_FU);
         idx = sum[PW-1:0];
         if (!found && req_i[idx]) begin
            gnt_o[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one result slot per functional unit, one broadcast per
// cycle chosen round-robin. XLEN must not exceed rv32i_types::RV_XLEN, the slot
// storage width.
module cdb_arbiter
   import rv32i_types::*;
#(
   parameter int NUM_FU = 4,
   parameter int XLEN   = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 flush,
   input  logic [NUM_FU-1:0]                    fu_valid,
   output logic [NUM_FU-1:0]                    fu_ready,
   input  logic [NUM_FU-1:0][PHYS_REG_IDX:0]    fu_pd,
   input  logic [NUM_FU-1:0][ROB_IDX_W-1:0]     fu_rob,
   input  logic [NUM_FU-1:0][XLEN-1:0]          fu_value,
   input  logic [NUM_FU-1:0]                    fu_dest_we,
   output logic                                 cdb_valid,
   output logic [PHYS_REG_IDX:0]                cdb_pid,
   output logic [ROB_IDX_W-1:0]                 cdb_rob,
   output logic [XLEN-1:0]                      cdb_value,
   output logic                                 cdb_we,
   output logic [$clog2(NUM_FU)-1:0]            cdb_src,
   output logic [31:0]                          stall_cnt
);

   localparam int PW = $clog2(NUM_FU);

   cdb_pkt_t          slot_q [NUM_FU];
   cdb_pkt_t          slot_d [NUM_FU];
   logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [31:0]       stall_cnt_q, stall_cnt_d;

   logic [NUM_FU-1:0] occ;
   logic [NUM_FU-1:0] grant;
   logic              any_gnt;
   logic [PW-1:0]     gidx;
   cdb_pkt_t          gpkt;

   // Occupancy vector feeding the arbiter.
   always_comb begin
      occ = '0;
      for (int i = 0; i < NUM_FU; i++) occ[i] = slot_q[i].valid;
   end

   rr_arbiter #(.NUM_FU(NUM_FU), .PW(PW)) u_rr (
      .req_i (occ),
      .ptr_i (rr_ptr_q),
      .gnt_o (grant)
   );

   // Encode the one-hot grant and pick out the winning slot.
   always_comb begin
      any_gnt = |grant;
      gidx    = '0;
      gpkt    = '0;
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            gidx = PW'(i);
            gpkt = slot_q[i];
         end
      end
   end

   // A slot can take a new result when empty or when it is draining this cycle.
   always_comb begin
      fu_ready = ~occ | grant;
   end

   // Broadcast payload; the destination is zeroed for non-writing completions.
   always_comb begin
      cdb_valid = 1'b0;
      cdb_pid   = '0;
      cdb_rob   = '0;
      cdb_value = '0;
      cdb_we    = 1'b0;
      cdb_src   = '0;
      if (any_gnt) begin
         cdb_valid = 1'b1;
         cdb_pid   = gpkt.dest_we ? gpkt.pd : '0;
         cdb_rob   = gpkt.rob;
         cdb_value = XLEN'(gpkt.value);
         cdb_we    = gpkt.dest_we;
         cdb_src   = gidx;
      end
   end

   // Next-state: flush wins, then a load, then the drain of the granted slot.
   always_comb begin
      for (int i = 0; i < NUM_FU; i++) begin
         slot_d[i] = slot_q[i];
         if (flush) begin
            slot_d[i] = '0;
         end else if (fu_valid[i] && fu_ready[i]) begin
            slot_d[i].valid   = 1'b1;
            slot_d[i].pd      = fu_pd[i];
            slot_d[i].rob     = fu_rob[i];
            slot_d[i].value   = RV_XLEN'(fu_value[i]);
            slot_d[i].dest_we = fu_dest_we[i];
         end else if (grant[i]) begin
            slot_d[i].valid = 1'b0;
         end
      end

      rr_ptr_d = rr_ptr_q;
      if (flush) begin
         rr_ptr_d = '0;
      end else if (any_gnt) begin
         rr_ptr_d = (gidx == PW'(NUM_FU-1)) ? '0 : gidx + PW'(1);
      end

      stall_cnt_d = stall_cnt_q;
      if ($countones(occ) > 1) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_FU; i++) slot_q[i] <= '0;
         rr_ptr_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         for (int i = 0; i < NUM_FU; i++) slot_q[i] <= slot_d[i];
         rr_ptr_q    <= rr_ptr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios then random traffic, all checked
// against a slot/queue-level reference model.
module tb_cdb_arbiter;
   import rv32i_types::*;

   localparam int N     = 4;
   localparam int XLEN  = 32;
   localparam int PW    = $clog2(N);
   localparam int PID_W = PHYS_REG_IDX + 1;
   localparam int ROB_W = ROB_IDX_W;

   logic                        clk;
   logic                        rst_n;
   logic                        flush;
   logic [N-1:0]                fu_valid;
   logic [N-1:0]                fu_ready;
   logic [N-1:0][PID_W-1:0]     fu_pd;
   logic [N-1:0][ROB_W-1:0]     fu_rob;
   logic [N-1:0][XLEN-1:0]      fu_value;
   logic [N-1:0]                fu_dest_we;
   logic                        cdb_valid;
   logic [PID_W-1:0]            cdb_pid;
   logic [ROB_W-1:0]            cdb_rob;
   logic [XLEN-1:0]             cdb_value;
   logic                        cdb_we;
   logic [PW-1:0]               cdb_src;
   logic [31:0]                 stall_cnt;

   cdb_arbiter #(.NUM_FU(N), .XLEN(XLEN)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .fu_valid   (fu_valid),
      .fu_ready   (fu_ready),
      .fu_pd      (fu_pd),
      .fu_rob     (fu_rob),
      .fu_value   (fu_value),
      .fu_dest_we (fu_dest_we),
      .cdb_valid  (cdb_valid),
      .cdb_pid    (cdb_pid),
      .cdb_rob    (cdb_rob),
      .cdb_value  (cdb_value),
      .cdb_we     (cdb_we),
      .cdb_src    (cdb_src),
      .stall_cnt  (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model: one record per FU slot plus pointer and stall counter
   bit          m_v   [N];
   int unsigned m_pd  [N];
   int unsigned m_rob [N];
   int unsigned m_val [N];
   bit          m_we  [N];
   int          m_ptr;
   int unsigned m_stall;

   // stimulus for the next cycle
   logic [N-1:0]            s_v;
   logic [N-1:0][PID_W-1:0] s_pd;
   logic [N-1:0][ROB_W-1:0] s_rob;
   logic [N-1:0][XLEN-1:0]  s_val;
   logic [N-1:0]            s_we;
   logic                    s_fl;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_pd[i] = 0; m_rob[i] = 0; m_val[i] = 0; m_we[i] = 0;
      end
      m_ptr   = 0;
      m_stall = 0;
   endtask

   task automatic idle_stim();
      s_v = '0; s_pd = '0; s_rob = '0; s_val = '0; s_we = '0; s_fl = 1'b0;
   endtask

   task automatic load_stim(input int fu, input int pd, input int rob, input int val, input bit we);
      s_v[fu]   = 1'b1;
      s_pd[fu]  = PID_W'(pd);
      s_rob[fu] = ROB_W'(rob);
      s_val[fu] = XLEN'(val);
      s_we[fu]  = we;
   endtask

   // One clock cycle: drive stimulus, check outputs against the model, advance the model.
   task automatic step();
      int g;
      int occ;
      logic [N-1:0] e_rdy;
      @(negedge clk);
      fu_valid = s_v; fu_pd = s_pd; fu_rob = s_rob; fu_value = s_val;
      fu_dest_we = s_we; flush = s_fl;
      #1;
      g = -1;
      occ = 0;
      for (int k = 0; k < N; k++) begin
         if (g < 0 && m_v[(m_ptr + k) % N]) g = (m_ptr + k) % N;
         if (m_v[k]) occ++;
      end
      for (int i = 0; i < N; i++) e_rdy[i] = !m_v[i] || (i == g);
      chk("fu_ready", 64'(fu_ready), 64'(e_rdy));
      chk("cdb_valid", 64'(cdb_valid), 64'(g >= 0));
      chk("cdb_src", 64'(cdb_src), (g >= 0) ? 64'(g) : 64'd0);
      chk("cdb_pid", 64'(cdb_pid), (g >= 0 && m_we[g]) ? 64'(m_pd[g]) : 64'd0);
      chk("cdb_rob", 64'(cdb_rob), (g >= 0) ? 64'(m_rob[g]) : 64'd0);
      chk("cdb_value", 64'(cdb_value), (g >= 0) ? 64'(m_val[g]) : 64'd0);
      chk("cdb_we", 64'(cdb_we), (g >= 0) ? 64'(m_we[g]) : 64'd0);
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
      if (occ > 1) m_stall = m_stall + 1;
      for (int i = 0; i < N; i++) begin
         if (s_fl) m_v[i] = 0;
         else if (s_v[i] && e_rdy[i]) begin
            m_v[i] = 1; m_pd[i] = int'(s_pd[i]); m_rob[i] = int'(s_rob[i]);
            m_val[i] = s_val[i]; m_we[i] = s_we[i];
         end else if (i == g) m_v[i] = 0;
      end
      if (s_fl) m_ptr = 0;
      else if (g >= 0) m_ptr = (g + 1) % N;
   endtask

   int unsigned base;

   initial begin
      rst_n = 1'b0;
      flush = 1'b0; fu_valid = '0; fu_pd = '0; fu_rob = '0; fu_value = '0; fu_dest_we = '0;
      model_reset();
      idle_stim();
      #1;
      chk("rst_valid", 64'(cdb_valid), 64'd0);
      chk("rst_ready", 64'(fu_ready), 64'hF);
      chk("rst_stall", 64'(stall_cnt), 64'd0);
      chk("rst_value", 64'(cdb_value), 64'd0);
      #22 rst_n = 1'b1;

      // single result from FU1
      idle_stim(); load_stim(1, 5, 3, 32'hDEADBEEF, 1'b1); step();
      idle_stim(); step();
      chk("single_valid", 64'(cdb_valid), 64'd1);
      chk("single_pid", 64'(cdb_pid), 64'd5);
      chk("single_value", 64'(cdb_value), 64'hDEADBEEF);
      chk("single_src", 64'(cdb_src), 64'd1);
      step();
      chk("single_gone", 64'(cdb_valid), 64'd0);

      // four-way conflict from a zeroed pointer
      idle_stim(); s_fl = 1'b1; step();
      idle_stim();
      for (int i = 0; i < N; i++) load_stim(i, 10 + i, i, 32'h100 + i, 1'b1);
      step();
      base = m_stall;
      idle_stim();
      for (int k = 0; k < N; k++) begin
         step();
         chk("conflict_src", 64'(cdb_src), 64'(k));
         chk("conflict_val", 64'(cdb_value), 64'(32'h100 + k));
      end
      step();
      chk("conflict_stall", 64'(stall_cnt - base), 64'd3);

      // back-to-back from FU2
      for (int k = 0; k < 3; k++) begin
         idle_stim(); load_stim(2, 20, 4 + k, 32'h10 + k, 1'b1); step();
         chk("b2b_ready", 64'(fu_ready[2]), 64'd1);
         if (k > 0) chk("b2b_value", 64'(cdb_value), 64'(32'h10 + k - 1));
      end
      idle_stim(); step();
      chk("b2b_last", 64'(cdb_value), 64'h12);

      // store completion
      idle_stim(); load_stim(3, 7, 9, 32'h55, 1'b0); step();
      idle_stim(); step();
      chk("store_valid", 64'(cdb_valid), 64'd1);
      chk("store_we", 64'(cdb_we), 64'd0);
      chk("store_pid", 64'(cdb_pid), 64'd0);
      chk("store_rob", 64'(cdb_rob), 64'd9);

      // flush with slots 0 and 2 occupied, FU1 presenting in the flush cycle
      idle_stim(); load_stim(0, 1, 1, 32'hA0, 1'b1); load_stim(2, 2, 2, 32'hA2, 1'b1); step();
      idle_stim(); load_stim(1, 3, 3, 32'hA1, 1'b1); s_fl = 1'b1; step();
      chk("flush_pre_valid", 64'(cdb_valid), 64'd1);
      idle_stim(); step();
      chk("flush_post_valid", 64'(cdb_valid), 64'd0);
      idle_stim(); load_stim(1, 4, 4, 32'hB1, 1'b1); load_stim(3, 6, 6, 32'hB3, 1'b1); step();
      idle_stim(); step();
      chk("flush_ptr_src", 64'(cdb_src), 64'd1);
      step();

      // asynchronous reset with three slots occupied
      idle_stim();
      for (int i = 0; i < 3; i++) load_stim(i, 30 + i, i, 32'hC0 + i, 1'b1);
      step();
      idle_stim(); step();
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 64'(cdb_valid), 64'd0);
      chk("midrst_ready", 64'(fu_ready), 64'hF);
      chk("midrst_stall", 64'(stall_cnt), 64'd0);
      model_reset();
      #3 rst_n = 1'b1;

      // random traffic
      for (int c = 0; c < 400; c++) begin
         idle_stim();
         for (int i = 0; i < N; i++) begin
            s_v[i]   = ($urandom_range(0, 99) < 55);
            s_pd[i]  = PID_W'($urandom);
            s_rob[i] = ROB_W'($urandom);
            s_val[i] = $urandom;
            s_we[i]  = ($urandom_range(0, 3) != 0);
         end
         s_fl = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4, meaning the number of functional-unit requesters (2..8).
REQ-002 SHALL have parameter XLEN, default 32, meaning the result data width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port flush  input  1  synchronous pipeline flush.
REQ-006 SHALL have port fu_valid  input  NUM_FU  per-FU result-valid.
REQ-007 SHALL have port fu_ready  output  NUM_FU  per-FU accept.
REQ-008 SHALL have port fu_pd  input  NUM_FU x (PHYS_REG_IDX+1)  per-FU destination physical register.
REQ-009 SHALL have port fu_rob  input  NUM_FU x ROB_IDX_W  per-FU ROB index.
REQ-010 SHALL have port fu_value  input  NUM_FU x XLEN  per-FU result value.
REQ-011 SHALL have port fu_dest_we  input  NUM_FU  per-FU register-write flag.
REQ-012 SHALL have port cdb_valid  output  1  broadcast valid.
REQ-013 SHALL have ports cdb_pid, cdb_rob, cdb_value and cdb_we as outputs of widths PHYS_REG_IDX+1, ROB_IDX_W, XLEN and 1, carrying the broadcast payload.
REQ-014 SHALL have port cdb_src  output  $clog2(NUM_FU)  index of the granted FU.
REQ-015 SHALL have port stall_cnt  output  32  count of cycles in which one or more occupied slots were not granted.

Function
REQ-016 SHALL hold one result slot per FU, holding valid, pd, rob, value and dest_we.
- Handshake: fu_valid[i] && fu_ready[i] at edge N loads slot i.
REQ-017 SHALL drive fu_ready[i] = !slot_valid[i] || grant[i].
- Combinational.
- A slot granted in cycle N can therefore accept a new result at the same edge.
REQ-018 SHALL grant at most one occupied slot per cycle, round-robin.
- Search starts at rr_ptr and wraps modulo NUM_FU.
REQ-019 SHALL set rr_ptr to (granted index + 1) mod NUM_FU after every grant.
- rr_ptr is unchanged when no slot is granted.
REQ-020 SHALL drive the cdb_* outputs combinationally from the granted slot.
- Latency: a result accepted at edge N appears on the CDB in cycle N+1 at the earliest.
REQ-021 SHALL hold cdb_valid=0 when no slot is occupied.
- In that case cdb_pid, cdb_rob, cdb_value, cdb_we and cdb_src are all 0.
REQ-022 SHALL force cdb_pid to 0 when the granted slot has dest_we=0.
- cdb_we is low in that case; cdb_valid still asserts so the ROB sees the completion.
REQ-023 SHALL clear the granted slot at the edge ending its broadcast cycle, unless the same edge reloads it (REQ-017).
REQ-024 SHALL, on flush, clear every slot, reset rr_ptr to 0 and ignore fu_valid in that cycle.
- fu_ready stays as computed; the accepted data is discarded.
- cdb_valid is still driven from the pre-flush state in the flush cycle.
REQ-025 SHALL increment stall_cnt, wrapping at 2^32, in each cycle where popcount(slot_valid) > 1.
- stall_cnt is not cleared by flush.
REQ-026 SHALL guarantee every occupied slot is granted within NUM_FU cycles (no starvation).

Reset
REQ-027 SHALL, while rst_n=0, asynchronously clear all slots, rr_ptr and stall_cnt.
- All outputs read 0, except fu_ready, which reads all-ones.
REQ-028 SHALL resume normal operation at the first clk edge after rst_n deasserts; reset asserted mid-broadcast drops that broadcast immediately.

Structure
REQ-029 SHALL take PHYS_REG_IDX, NUM_ROB_ENTRIES and the cdb_pkt_t struct (valid, pd, rob, value, dest_we) from rv32i_types.
- ROB_IDX_W = $clog2(NUM_ROB_ENTRIES).
REQ-030 SHALL contain one sub-module, rr_arbiter (request vector + pointer in, one-hot grant out), which is combinational and parameterised by NUM_FU.

Verification
REQ-031 Single result: FU1 presents pd=5, rob=3, value=0xDEADBEEF, dest_we=1 at edge 0 -> cycle 1: cdb_valid=1, cdb_pid=5, cdb_value=0xDEADBEEF, cdb_src=1; cycle 2: cdb_valid=0.
REQ-032 Four-way conflict: all 4 FUs load at edge 0 with rr_ptr=0 -> grants 0,1,2,3 in cycles 1-4; stall_cnt=3.
REQ-033 Back-to-back from one FU: FU2 holds fu_valid=1 with values 0x10, 0x11, 0x12 -> fu_ready[2] stays 1 and the CDB shows 0x10, 0x11, 0x12 on consecutive cycles.
REQ-034 Store completion: FU3 presents dest_we=0, pd=7 -> cdb_valid=1, cdb_we=0, cdb_pid=0, cdb_rob as presented.
REQ-035 Flush: slots 0 and 2 occupied, flush at edge N -> cycle N+1: cdb_valid=0, rr_ptr=0, and a fu_valid presented in cycle N is not broadcast.
REQ-036 Reset mid-operation: drop rst_n while 3 slots are occupied -> the same cycle shows cdb_valid=0, fu_ready=4'b1111 and stall_cnt=0.
